// File: rtl/uart_tx_arbiter_pkg.sv
// Purpose: shared types and limits for the UART transmit arbiter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package uart_tx_arbiter_pkg;

    // Sequencer states: IDLE (no lock), LOCK (owner only), STROBE (one cycle), WAIT (UART busy)
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK   = 2'd1,
        ST_STROBE = 2'd2,
        ST_WAIT   = 2'd3
    } arb_state_t;

    // Legal range for the number of requesters
    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 8;

    // Width of a requester index
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Purpose: bundle of requester-side and UART-side signals of the transmit arbiter.
// Latency: n/a (wires only).
// Backpressure: reqReady acknowledges a held reqValid byte; txRdy gates txStb.
// Ports (slave = arbiter side):
//   reqValid/reqData/reqLast  in   per-requester byte offer (byte i in bits [8i+7:8i])
//   reqReady                  out  one-cycle acknowledge per requester
//   txData/txStb              out  byte and one-cycle strobe to the UART
//   txRdy                     in   UART ready
//   grant/busy/lockDrop       out  owner one-hot, not-idle flag, lock-timeout pulse
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   reqValid;
    logic [8*NREQ-1:0] reqData;
    logic [NREQ-1:0]   reqLast;
    logic [NREQ-1:0]   reqReady;
    logic [7:0]        txData;
    logic              txStb;
    logic              txRdy;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              lockDrop;

    // Requesters plus UART (the environment around the arbiter)
    modport master (
        output reqValid, reqData, reqLast, txRdy,
        input  reqReady, txData, txStb, grant, busy, lockDrop
    );

    // The arbiter itself
    modport slave (
        input  reqValid, reqData, reqLast, txRdy,
        output reqReady, txData, txStb, grant, busy, lockDrop
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Purpose: combinational round-robin picker, first masked request after i_last (wrapping).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; o_any low means nothing eligible.
// Ports:
//   i_req     requests           i_last    index of previous winner
//   i_mask    eligible set       o_onehot  winner one-hot
//   o_idx     winner index       o_any     a winner exists
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    input  logic [NREQ-1:0]  i_mask,
    output logic [NREQ-1:0]  o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [NREQ-1:0] w_cand;
    assign w_cand = i_req & i_mask;

    always_comb begin
        // One spare bit so last+k (at most 2*NREQ-1) cannot overflow before the wrap
        logic [IDX_W:0]   w_sum;
        logic [IDX_W-1:0] w_pos;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_sum    = '0;
        w_pos    = '0;
        // Visit last+1 .. last+NREQ; the previous winner is checked last
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, i_last} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NREQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NREQ);
            end
            w_pos = w_sum[IDX_W-1:0];
            if (!o_any && w_cand[w_pos]) begin
                o_any           = 1'b1;
                o_idx           = w_pos;
                o_onehot[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter/sequencer sharing one UART transmitter among NREQ byte requesters.
// Latency: request seen with txRdy high -> txStb/reqReady next cycle; strobes >= 3 cycles apart.
// Backpressure: no strobe while txRdy is low; a byte is held by its requester until reqReady.
// Ports: i_sysclk (clock), i_rst_n (async active-low reset), io_arb (uart_tx_arbiter_if.slave).
// Optional: UART_ARB_TIMEOUT_EN builds the lock-timeout counter and drives lockDrop.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             i_sysclk,
    input  logic             i_rst_n,
    uart_tx_arbiter_if.slave io_arb
);

    localparam int IDX_W = idx_width(NREQ);

    if (NREQ < NREQ_MIN || NREQ > NREQ_MAX || TIMEOUT < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    arb_state_t       r_state, w_state_nxt;
    logic [7:0]       r_tx_data, w_tx_data_nxt;
    logic             r_tx_stb, w_tx_stb_nxt;
    logic [NREQ-1:0]  r_req_ready, w_req_ready_nxt;
    logic [NREQ-1:0]  r_grant, w_grant_nxt;
    logic             r_busy, w_busy_nxt;
    logic [IDX_W-1:0] r_last, w_last_nxt;
    logic             r_lock, w_lock_nxt;

    logic [NREQ-1:0]  w_mask;
    logic [NREQ-1:0]  w_pick_onehot;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic [7:0]       w_win_data;
    logic             w_win_last;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_to_cnt, w_to_cnt_nxt, w_to_cnt_inc;
    logic             r_lock_drop, w_lock_drop_nxt;
    logic             w_lock_vld;

    // While locked, grant is the one-hot of the lock owner
    assign w_lock_vld   = |(io_arb.reqValid & r_grant);
    assign w_to_cnt_inc = r_to_cnt + 1'b1;
`endif

    // In LOCK only the owner (held in grant) is eligible
    assign w_mask = (r_state == ST_LOCK) ? r_grant : '1;

    uart_tx_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req    (io_arb.reqValid),
        .i_last   (r_last),
        .i_mask   (w_mask),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_win_data = io_arb.reqData[{w_pick_idx, 3'b000} +: 8];
    assign w_win_last = io_arb.reqLast[w_pick_idx];

    always_comb begin
        w_state_nxt     = r_state;
        w_tx_data_nxt   = r_tx_data;
        w_tx_stb_nxt    = 1'b0;
        w_req_ready_nxt = '0;
        w_grant_nxt     = r_grant;
        w_last_nxt      = r_last;
        w_lock_nxt      = r_lock;
`ifdef UART_ARB_TIMEOUT_EN
        w_to_cnt_nxt    = r_to_cnt;
        w_lock_drop_nxt = 1'b0;
`endif
        case (r_state)
            ST_IDLE, ST_LOCK: begin
                if (io_arb.txRdy && w_pick_any) begin
                    w_tx_data_nxt   = w_win_data;
                    w_tx_stb_nxt    = 1'b1;
                    w_req_ready_nxt = w_pick_onehot;
                    w_grant_nxt     = w_pick_onehot;
                    w_last_nxt      = w_pick_idx;
                    // A byte without reqLast keeps the line reserved for this requester
                    w_lock_nxt      = ~w_win_last;
                    w_state_nxt     = ST_STROBE;
`ifdef UART_ARB_TIMEOUT_EN
                    w_to_cnt_nxt    = '0;
`endif
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (r_state == ST_LOCK) begin
                    if (w_lock_vld) begin
                        w_to_cnt_nxt = '0;
                    end else if (w_to_cnt_inc == CNT_W'(TIMEOUT)) begin
                        // Owner went silent too long; last already points at it
                        w_to_cnt_nxt    = '0;
                        w_lock_nxt      = 1'b0;
                        w_grant_nxt     = '0;
                        w_lock_drop_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_to_cnt_nxt = w_to_cnt_inc;
                    end
                end
`endif
            end
            ST_STROBE: begin
                // txRdy only falls a cycle after the strobe, so it is not trusted here
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (io_arb.txRdy) begin
                    if (r_lock) begin
                        w_state_nxt = ST_LOCK;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_tx_data   <= '0;
            r_tx_stb    <= 1'b0;
            r_req_ready <= '0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_last      <= IDX_W'(NREQ - 1);
            r_lock      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_lock_drop <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_stb    <= w_tx_stb_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_grant     <= w_grant_nxt;
            r_busy      <= w_busy_nxt;
            r_last      <= w_last_nxt;
            r_lock      <= w_lock_nxt;
`ifdef UART_ARB_TIMEOUT_EN
            r_to_cnt    <= w_to_cnt_nxt;
            r_lock_drop <= w_lock_drop_nxt;
`endif
        end
    end

    assign io_arb.reqReady = r_req_ready;
    assign io_arb.txData   = r_tx_data;
    assign io_arb.txStb    = r_tx_stb;
    assign io_arb.grant    = r_grant;
    assign io_arb.busy     = r_busy;
`ifdef UART_ARB_TIMEOUT_EN
    assign io_arb.lockDrop = r_lock_drop;
`else
    assign io_arb.lockDrop = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: directed self-checking bench for uart_tx_arbiter with a small UART ready model.
// Latency: n/a.
// Backpressure: the UART model drops txRdy one cycle after each strobe for four cycles.
module tb_uart_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic force_rdy_low = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] line_q[$];
    int   stb_cnt = 0;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus();

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .i_sysclk (clk),
        .i_rst_n  (rst_n),
        .io_arb   (bus.slave)
    );

    always #5 clk = ~clk;

    // UART: txRdy falls the cycle after txStb and returns four cycles later (driven at edge+1)
    initial begin : uart_model
        int   busy_left;
        logic pending;
        busy_left  = 0;
        pending    = 1'b0;
        bus.txRdy  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (pending) begin
                bus.txRdy = 1'b0;
                busy_left = 4;
                pending   = 1'b0;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) bus.txRdy = !force_rdy_low;
            end else begin
                bus.txRdy = !force_rdy_low;
            end
            if (bus.txStb === 1'b1) pending = 1'b1;
        end
    end

    // Line capture (edge+2)
    initial begin : line_monitor
        forever begin
            @(posedge clk);
            #2;
            if (bus.txStb === 1'b1) begin
                line_q.push_back(bus.txData);
                stb_cnt++;
            end
        end
    end

    // Tests sample and drive at edge+3
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_stb(input int max_cyc, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        while (!ok && waited < max_cyc) begin
            tick();
            waited++;
            if (bus.txStb === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        while (!ok && waited < max_cyc) begin
            tick();
            waited++;
            if (bus.busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        force_rdy_low = 1'b0;
        bus.reqValid = '0;
        bus.reqData  = '0;
        bus.reqLast  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [20:0] got;
        bus.reqValid = '0;
        bus.reqData  = '0;
        bus.reqLast  = '0;
        rst_n = 1'b0;
        tick();
        tick();
        got = {bus.reqReady, bus.txData, bus.txStb, bus.grant, bus.busy, bus.lockDrop};
        checks++;
        if (got !== 21'd0) begin
            failures++;
            $display("FAIL reset_asserted: outputs=%h expected 0", got);
        end
        rst_n = 1'b1;
        tick();
        tick();
        got = {bus.reqReady, bus.txData, bus.txStb, bus.grant, bus.busy, bus.lockDrop};
        checks++;
        if (got !== 21'd0) begin
            failures++;
            $display("FAIL reset_released_idle: outputs=%h expected 0", got);
        end
    endtask

    task automatic test_single_byte();
        bit ok;
        int n;
        int n0;
        n0 = stb_cnt;
        bus.reqData  = 32'h0000_0055;
        bus.reqLast  = 4'b0001;
        bus.reqValid = 4'b0001;
        tick();
        checks++;
        if ({bus.txStb, bus.txData, bus.reqReady, bus.grant, bus.busy} !== {1'b1, 8'h55, 4'b0001, 4'b0001, 1'b1}) begin
            failures++;
            $display("FAIL single_accept: stb=%b data=%h rdy=%b grant=%b busy=%b expected 1 55 0001 0001 1",
                     bus.txStb, bus.txData, bus.reqReady, bus.grant, bus.busy);
        end
        tick();
        bus.reqValid = '0;
        checks++;
        if ({bus.txStb, bus.reqReady, bus.busy} !== {1'b0, 4'b0000, 1'b1}) begin
            failures++;
            $display("FAIL single_strobe_len: stb=%b rdy=%b busy=%b expected 0 0000 1",
                     bus.txStb, bus.reqReady, bus.busy);
        end
        wait_idle(20, ok, n);
        checks++;
        if (!ok || n != 5 || bus.grant !== 4'b0000) begin
            failures++;
            $display("FAIL single_busy_until_rdy: idle=%0d cycles=%0d grant=%b expected 1 5 0000", ok, n, bus.grant);
        end
        checks++;
        if (stb_cnt != n0 + 1 || line_q[$] !== 8'h55) begin
            failures++;
            $display("FAIL single_line: strobes=%0d last=%h expected %0d 55", stb_cnt - n0, line_q[$], 1);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        int n;
        do_reset();
        bus.reqData  = 32'h0022_1100;
        bus.reqLast  = 4'b0110;
        bus.reqValid = 4'b0110;
        tick();
        checks++;
        if ({bus.txStb, bus.txData, bus.reqReady, bus.grant} !== {1'b1, 8'h11, 4'b0010, 4'b0010}) begin
            failures++;
            $display("FAIL simul_first: stb=%b data=%h rdy=%b grant=%b expected 1 11 0010 0010",
                     bus.txStb, bus.txData, bus.reqReady, bus.grant);
        end
        tick();
        bus.reqValid = 4'b0100;
        wait_stb(30, ok, n);
        checks++;
        if (!ok || {bus.txData, bus.reqReady, bus.grant} !== {8'h22, 4'b0100, 4'b0100}) begin
            failures++;
            $display("FAIL simul_second: seen=%0d data=%h rdy=%b grant=%b expected 1 22 0100 0100",
                     ok, bus.txData, bus.reqReady, bus.grant);
        end
        checks++;
        if (n + 1 != 7) begin
            failures++;
            $display("FAIL simul_gap: strobe gap=%0d expected 7", n + 1);
        end
        tick();
        bus.reqValid = '0;
        wait_idle(20, ok, n);
    endtask

    task automatic test_packet_lock();
        bit ok;
        int n;
        int n0;
        logic [7:0] exp_d[4];
        logic [3:0] exp_g[4];
        logic [31:0] got;
        exp_d = '{8'hA1, 8'hA2, 8'hA3, 8'h33};
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b1000};
        do_reset();
        n0 = line_q.size();
        bus.reqData  = 32'h3300_00A1;
        bus.reqLast  = 4'b1000;
        bus.reqValid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            wait_stb(30, ok, n);
            checks++;
            if (!ok || bus.txData !== exp_d[i] || bus.grant !== exp_g[i]) begin
                failures++;
                $display("FAIL lock_byte%0d: seen=%0d data=%h grant=%b expected 1 %h %b",
                         i, ok, bus.txData, bus.grant, exp_d[i], exp_g[i]);
            end
            tick();
            if (bus.grant[0]) begin
                if (bus.reqData[7:0] == 8'hA1)      bus.reqData[7:0] = 8'hA2;
                else if (bus.reqData[7:0] == 8'hA2) begin
                    bus.reqData[7:0] = 8'hA3;
                    bus.reqLast[0]   = 1'b1;
                end else bus.reqValid[0] = 1'b0;
            end else if (bus.grant[3]) begin
                bus.reqValid[3] = 1'b0;
            end
        end
        wait_idle(30, ok, n);
        got = (line_q.size() >= n0 + 4) ? {line_q[n0], line_q[n0+1], line_q[n0+2], line_q[n0+3]} : 32'h0;
        checks++;
        if (line_q.size() != n0 + 4 || got !== 32'hA1A2A333) begin
            failures++;
            $display("FAIL lock_order: count=%0d line=%h expected 4 a1a2a333", line_q.size() - n0, got);
        end
    endtask

    task automatic test_txrdy_gating();
        bit ok;
        int n;
        int seen;
        force_rdy_low = 1'b1;
        tick();
        bus.reqData  = 32'h4342_4140;
        bus.reqLast  = 4'b1111;
        bus.reqValid = 4'b1111;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.txStb === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL gate_hold: strobes=%0d busy=%b expected 0 0", seen, bus.busy);
        end
        force_rdy_low = 1'b0;
        wait_stb(10, ok, n);
        checks++;
        if (!ok || n != 2 || bus.txData !== 8'h40 || bus.reqReady !== 4'b0001) begin
            failures++;
            $display("FAIL gate_release: seen=%0d cycles=%0d data=%h rdy=%b expected 1 2 40 0001",
                     ok, n, bus.txData, bus.reqReady);
        end
        tick();
        bus.reqValid = '0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.txStb === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL gate_single: extra strobes=%0d expected 0", seen);
        end
    endtask

    task automatic test_lock_timeout();
        bit ok;
        int n;
        do_reset();
        bus.reqData  = 32'h0022_0010;
        bus.reqLast  = 4'b0100;
        bus.reqValid = 4'b0101;
        wait_stb(5, ok, n);
        checks++;
        if (!ok || bus.txData !== 8'h10 || bus.grant !== 4'b0001) begin
            failures++;
            $display("FAIL to_first: seen=%0d data=%h grant=%b expected 1 10 0001", ok, bus.txData, bus.grant);
        end
        tick();
        bus.reqValid = 4'b0100;
`ifdef UART_ARB_TIMEOUT_EN
        begin
            int rise_c, drop_c, drops, stb_c;
            logic prev_rdy;
            logic [3:0] drop_grant, stb_grant;
            logic [7:0] stb_data;
            rise_c = -1; drop_c = -1; drops = 0; stb_c = -1;
            prev_rdy = bus.txRdy;
            drop_grant = 'x; stb_grant = 'x; stb_data = 'x;
            for (int c = 1; c <= 60; c++) begin
                tick();
                if (bus.txRdy && !prev_rdy && rise_c < 0) rise_c = c;
                prev_rdy = bus.txRdy;
                if (bus.lockDrop === 1'b1) begin
                    drops++;
                    drop_c = c;
                    drop_grant = bus.grant;
                end
                if (bus.txStb === 1'b1 && stb_c < 0) begin
                    stb_c = c;
                    stb_data = bus.txData;
                    stb_grant = bus.grant;
                end
                if (stb_c > 0 && c == stb_c + 1) bus.reqValid = '0;
            end
            checks++;
            if (drops != 1 || drop_c - rise_c != 17 || drop_grant !== 4'b0000) begin
                failures++;
                $display("FAIL to_drop: pulses=%0d drop-rise=%0d grant=%b expected 1 17 0000",
                         drops, drop_c - rise_c, drop_grant);
            end
            checks++;
            if (stb_c != drop_c + 1 || stb_data !== 8'h22 || stb_grant !== 4'b0100) begin
                failures++;
                $display("FAIL to_next: stb-drop=%0d data=%h grant=%b expected 1 22 0100",
                         stb_c - drop_c, stb_data, stb_grant);
            end
        end
`else
        begin
            int seen, drops;
            seen = 0; drops = 0;
            for (int c = 0; c < 1000; c++) begin
                tick();
                if (bus.txStb === 1'b1) seen++;
                if (bus.lockDrop === 1'b1) drops++;
            end
            checks++;
            if (seen != 0 || drops != 0 || bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL to_off_hold: strobes=%0d drops=%0d grant=%b busy=%b expected 0 0 0001 1",
                         seen, drops, bus.grant, bus.busy);
            end
        end
`endif
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        int n;
        logic [20:0] got;
        do_reset();
        bus.reqData  = 32'h0000_5A00;
        bus.reqLast  = 4'b0010;
        bus.reqValid = 4'b0010;
        wait_stb(5, ok, n);
        tick();
        bus.reqData = 32'h0000_6B00;
        checks++;
        if (!ok || bus.busy !== 1'b1 || bus.txRdy !== 1'b0) begin
            failures++;
            $display("FAIL rstwait_setup: seen=%0d busy=%b txRdy=%b expected 1 1 0", ok, bus.busy, bus.txRdy);
        end
        rst_n = 1'b0;
        #1;
        got = {bus.reqReady, bus.txData, bus.txStb, bus.grant, bus.busy, bus.lockDrop};
        checks++;
        if (got !== 21'd0) begin
            failures++;
            $display("FAIL rstwait_async: outputs=%h expected 0", got);
        end
        tick();
        tick();
        rst_n = 1'b1;
        wait_stb(10, ok, n);
        checks++;
        if (!ok || n != 3 || bus.txData !== 8'h6B || bus.reqReady !== 4'b0010) begin
            failures++;
            $display("FAIL rstwait_resume: seen=%0d cycles=%0d data=%h rdy=%b expected 1 3 6b 0010",
                     ok, n, bus.txData, bus.reqReady);
        end
        tick();
        bus.reqValid = '0;
        wait_idle(20, ok, n);
    endtask

    initial begin
        bus.reqValid = '0;
        bus.reqData  = '0;
        bus.reqLast  = '0;
        test_reset();
        test_single_byte();
        test_simultaneous();
        test_packet_lock();
        test_txrdy_gating();
        test_lock_timeout();
        test_reset_in_wait();
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
